// File: rtl/perf_frame_tx.sv
// perf_frame_tx: latches NUM_WORDS counter words and streams them to uart_tx as sync, count, LE data bytes.
// Define PERF_FRAME_CHECKSUM_EN to append an 8-bit wrap-around sum of every byte after the sync byte.
module perf_frame_tx #(
  parameter int         NUM_WORDS = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    snap_i,
  input  logic [32*NUM_WORDS-1:0] data_i,
  input  logic                    tx_busy_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_start_o,
  output logic                    frame_busy_o,
  output logic                    frame_done_o,
  output logic                    snap_drop_o
);

  localparam int NUM_BYTES = 4 * NUM_WORDS;
`ifdef PERF_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_BYTES + 3;
`else
  localparam int FRAME_LEN = NUM_BYTES + 2;
`endif
  localparam int               IDX_W      = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0]       COUNT_BYTE = 8'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t                    state_q, state_d;
  logic [NUM_BYTES-1:0][7:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]          idx_q, idx_d, idx_inc;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      tx_start_q, tx_start_d;
  logic                      busy_q, busy_d;
  logic [7:0]                next_byte;
  logic                      last_byte;
`ifdef PERF_FRAME_CHECKSUM_EN
  logic [7:0]                csum_q, csum_d;
`endif

  assign idx_inc   = idx_q + IDX_W'(1);
  assign last_byte = (idx_q == LAST_IDX);

  // Byte that follows the one currently on the wire; the sync byte is issued straight from IDLE.
  always_comb begin
    next_byte = COUNT_BYTE;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx_inc == IDX_W'(i + 2)) next_byte = shadow_q[i];
    end
`ifdef PERF_FRAME_CHECKSUM_EN
    if (idx_inc == LAST_IDX) next_byte = csum_q;
`endif
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
`ifdef PERF_FRAME_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (snap_i) begin
          shadow_d   = data_i;
          idx_d      = '0;
          tx_data_d  = SYNC_BYTE;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = SEND;
`ifdef PERF_FRAME_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      SEND: state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy_i) begin
          if (last_byte) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d      = idx_inc;
            tx_data_d  = next_byte;
            tx_start_d = 1'b1;
            state_d    = SEND;
`ifdef PERF_FRAME_CHECKSUM_EN
            if (idx_inc != LAST_IDX) csum_d = csum_q + next_byte;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PERF_FRAME_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
`ifdef PERF_FRAME_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign frame_busy_o = busy_q;
  // Done and drop flag the very cycle their condition is seen, so IDLE can accept a snapshot next cycle.
  assign frame_done_o = (state_q == WAIT_LO) && !tx_busy_i && last_byte;
  assign snap_drop_o  = snap_i && (state_q != IDLE);

endmodule

// File: tb/tb_perf_frame_tx.sv
// tb_perf_frame_tx: directed frames against perf_frame_tx with NUM_WORDS=2 and a uart_tx busy model.
`timescale 1ns/1ps
module tb_perf_frame_tx;
`ifdef PERF_FRAME_CHECKSUM_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        snap_i;
  logic [63:0] data_i;
  logic        tx_busy_i;
  logic [7:0]  tx_data_o;
  logic        tx_start_o, frame_busy_o, frame_done_o, snap_drop_o;

  perf_frame_tx #(.NUM_WORDS(2), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rstn(rstn), .snap_i(snap_i), .data_i(data_i), .tx_busy_i(tx_busy_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .frame_busy_o(frame_busy_o),
    .frame_done_o(frame_done_o), .snap_drop_o(snap_drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_t1 [11] = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h17};
  logic [7:0] exp_t3 [11] = '{8'hA5, 8'h02, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'h0B, 8'h2C};
  logic [7:0] exp_t6 [11] = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFA};
  localparam logic [63:0] W_T1 = {32'h12345678, 32'h00000001};
  localparam logic [63:0] W_T3 = {32'h0BADBEEF, 32'hCAFEF00D};

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // uart_tx model: busy rises in the tx_start cycle and stays high busy_hold cycles.
  int busy_hold = 10;
  int busy_left = 0;
  initial begin
    tx_busy_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tx_start_o === 1'b1) busy_left = busy_hold;
      else if (busy_left > 0) busy_left--;
      tx_busy_i = (busy_left > 0);
    end
  end

  logic [7:0] sb_q[$];
  int         sc_q[$];
  int done_cnt = 0, done_cyc = 0, drop_cnt = 0, drop_cyc = 0, busy_cyc_cnt = 0, busy_last = 0;
  always @(negedge clk) begin
    if (tx_start_o === 1'b1) begin
      sb_q.push_back(tx_data_o);
      sc_q.push_back(cyc);
    end
    if (frame_done_o === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (snap_drop_o === 1'b1) begin drop_cnt++; drop_cyc = cyc; end
    if (frame_busy_o === 1'b1) begin busy_cyc_cnt++; busy_last = cyc; end
  end

  task automatic run_frame(input string tag, input logic [63:0] words, input logic [7:0] exp [11],
                           input int hold, input bit mid_snap, input logic [63:0] alt_words);
    int b_s, b_d, b_dr, t0, k_drop, guard;
    busy_hold = hold;
    data_i    = words;
    b_s  = sc_q.size();
    b_d  = done_cnt;
    b_dr = drop_cnt;
    snap_i = 1'b1;
    t0 = cyc;
    step();
    snap_i = 1'b0;
    if (mid_snap) begin
      guard = 0;
      while (sc_q.size() < b_s + 3 && guard < 500) begin step(); guard++; end
      snap_i = 1'b1;
      k_drop = cyc;
      step();
      snap_i = 1'b0;
      data_i = alt_words;
      check_eq({tag, "_drop_cyc"}, drop_cyc, k_drop);
    end
    guard = 0;
    while (done_cnt == b_d && guard < 3000) begin step(); guard++; end
    repeat (30) step();
    check_eq({tag, "_done_cnt"}, done_cnt - b_d, 1);
    check_eq({tag, "_drop_cnt"}, drop_cnt - b_dr, mid_snap ? 1 : 0);
    check_eq({tag, "_nbytes"}, sc_q.size() - b_s, FL);
    if (sc_q.size() >= b_s + FL) begin
      for (int i = 0; i < FL; i++) check_eq($sformatf("%s_b%0d", tag, i), sb_q[b_s + i], exp[i]);
      check_eq({tag, "_first_lat"}, sc_q[b_s] - t0, 1);
      check_eq({tag, "_spacing"}, sc_q[b_s + FL - 1] - sc_q[b_s], (hold + 1) * (FL - 1));
      check_eq({tag, "_done_lat"}, done_cyc - sc_q[b_s + FL - 1], hold);
    end
    check_eq({tag, "_busy_fall"}, busy_last, done_cyc);
  endtask

  initial begin
    int b_s, b_d, b_dr, b_b, d1, guard;
    rstn   = 1'b0;
    snap_i = 1'b0;
    data_i = '0;
    repeat (3) step();
    check_eq("rst_tx_data", tx_data_o, 0);
    check_eq("rst_tx_start", tx_start_o, 0);
    check_eq("rst_busy", frame_busy_o, 0);
    check_eq("rst_done", frame_done_o, 0);
    check_eq("rst_drop", snap_drop_o, 0);
    rstn = 1'b1;
    repeat (2) step();

    run_frame("t1", W_T1, exp_t1, 10, 1'b0, 64'h0);
    run_frame("t3", W_T3, exp_t3, 10, 1'b1, 64'h5555AAAA_3C3C3C3C);

    // Reset while the sixth byte (index 5, 0xCA) is shifting out.
    busy_hold = 10;
    data_i = W_T3;
    b_s = sc_q.size();
    snap_i = 1'b1;
    step();
    snap_i = 1'b0;
    guard = 0;
    while (sc_q.size() < b_s + 6 && guard < 500) begin step(); guard++; end
    repeat (3) step();
    check_eq("t4_pre_byte", tx_data_o, 8'hCA);
    check_eq("t4_pre_busy", frame_busy_o, 1);
    snap_i = 1'b1;
    rstn   = 1'b0;
    #1;
    check_eq("t4_rst_tx_data", tx_data_o, 0);
    check_eq("t4_rst_tx_start", tx_start_o, 0);
    check_eq("t4_rst_busy", frame_busy_o, 0);
    check_eq("t4_rst_done", frame_done_o, 0);
    check_eq("t4_rst_drop", snap_drop_o, 0);
    snap_i = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    step();
    run_frame("t4b", W_T1, exp_t1, 10, 1'b0, 64'h0);

    // Back-to-back frames with snap_i held high.
    busy_hold = 10;
    data_i = W_T1;
    b_s  = sc_q.size();
    b_d  = done_cnt;
    b_dr = drop_cnt;
    b_b  = busy_cyc_cnt;
    snap_i = 1'b1;
    guard = 0;
    while (done_cnt == b_d && guard < 3000) begin step(); guard++; end
    d1 = done_cyc;
    check_eq("t5_drops", drop_cnt - b_dr, 11 * FL);
    check_eq("t5_busy_cycles", busy_cyc_cnt - b_b, 11 * FL);
    guard = 0;
    while (sc_q.size() <= b_s + FL && guard < 100) begin step(); guard++; end
    snap_i = 1'b0;
    check_eq("t5_nstart2", (sc_q.size() > b_s + FL) ? 1 : 0, 1);
    if (sc_q.size() > b_s + FL) begin
      check_eq("t5_gap", sc_q[b_s + FL] - d1, 2);
      check_eq("t5_sync2", sb_q[b_s + FL], 8'hA5);
    end
    guard = 0;
    while (done_cnt < b_d + 2 && guard < 3000) begin step(); guard++; end
    repeat (30) step();
    check_eq("t5_done_cnt", done_cnt - b_d, 2);
    check_eq("t5_nbytes", sc_q.size() - b_s, 2 * FL);

    run_frame("t6", {32'hFFFFFFFF, 32'hFFFFFFFF}, exp_t6, 2, 1'b0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/perf_frame_tx.md
# perf_frame_tx

- Frames a snapshot of the performance-counter words into a byte stream for the UART transmitter.
- Sits between the hit/miss counter block and `uart_tx`.
- On a snapshot request it latches all counter words and emits the frame one byte at a time: sync byte, word count, little-endian data bytes, optional checksum.
- Each byte is handed to `uart_tx` with a `tx_start`/`tx_busy` handshake.

## Interface

Parameters:
- `NUM_WORDS`, default 8: number of 32-bit words per frame (1..63).
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

Ports:
- `clk`, input, 1: single clock. One clock; reset is asynchronous and active-low.
- `rstn`, input, 1: asynchronous active-low reset.
- `snap_i`, input, 1: snapshot request, sampled every cycle.
- `data_i`, input, 32*NUM_WORDS: counter words; word k is `data_i[32k+31:32k]`.
- `tx_busy_i`, input, 1: `uart_tx` busy; high while a byte is shifting out.
- `tx_data_o`, output, 8: byte presented to `uart_tx`.
- `tx_start_o`, output, 1: one-cycle pulse; `uart_tx` loads `tx_data_o`.
- `frame_busy_o`, output, 1: high from snapshot latch until the last byte completes.
- `frame_done_o`, output, 1: one-cycle pulse when the final byte's `tx_busy_i` falls.
- `snap_drop_o`, output, 1: one-cycle pulse when `snap_i` arrives while busy.

## Operation

Frame order:
- `SYNC_BYTE`
- `NUM_WORDS[7:0]`
- word 0 byte 0 (LSB) .. word 0 byte 3
- word 1 byte 0 .. through word `NUM_WORDS-1` byte 3
- checksum (only when configured)

Frame length is `2+4*NUM_WORDS` bytes, plus 1 with checksum.

State machine:
- IDLE:
  - `snap_i`=1: latch `data_i` into a shadow register, clear the byte index and checksum, go to SEND.
  - Otherwise stay.
- SEND: drive `tx_data_o` = current byte, pulse `tx_start_o`, go to WAIT_HI.
- WAIT_HI: stay until `tx_busy_i`=1, then go to WAIT_LO.
- WAIT_LO: stay until `tx_busy_i`=0, then:
  - Last byte: pulse `frame_done_o`, go to IDLE.
  - Otherwise: increment the byte index, go to SEND.

Rules:
- Checksum is the 8-bit wrap-around sum (mod 256) of every byte after the sync byte, including the count byte. It is accumulated as each byte is issued.
- Shadow data is held stable for the whole frame; `data_i` changes mid-frame have no effect.
- `snap_i` in any state other than IDLE is ignored and pulses `snap_drop_o` that cycle. The current frame is unaffected.
- The byte-index counter is sized to hold the frame length. It never wraps within a frame and is cleared on each new snapshot.

## Timing

Reset values (all outputs 0, state IDLE):
- `tx_data_o`=0, `tx_start_o`=0, `frame_busy_o`=0, `frame_done_o`=0, `snap_drop_o`=0.
- Shadow register, byte index and checksum are 0.

Cycle behaviour:
- `snap_i` high at edge t: `frame_busy_o`=1 from t+1; first `tx_start_o` at t+1 with `tx_data_o`=`SYNC_BYTE`.
- `tx_data_o` is registered and stays stable from the `tx_start_o` cycle until the next SEND.
- Minimum spacing between `tx_start_o` pulses is 3 cycles: SEND, WAIT_HI, WAIT_LO. The actual spacing is set by `tx_busy_i`.
- `frame_done_o` fires in the cycle WAIT_LO sees `tx_busy_i`=0 for the last byte. `frame_busy_o` falls the following cycle.
- A new `snap_i` is accepted in the first IDLE cycle, which is the cycle after `frame_done_o`.
- `rstn` asserted mid-frame:
  - All outputs clear immediately.
  - The partial frame is abandoned and is not resumed.
  - The receiver resynchronises on `SYNC_BYTE`.
- `tx_busy_i` already high on entry to WAIT_HI is legal and passes on the next edge.

## Configuration

- Macro: `PERF_FRAME_CHECKSUM_EN`.
- Defined: the checksum byte is appended, and frame length is `3+4*NUM_WORDS`.
- Undefined:
  - No checksum logic is built.
  - The frame ends after word `NUM_WORDS-1` byte 3, and frame length is `2+4*NUM_WORDS`.
  - `frame_done_o` fires on that byte.

## Test plan

1. Frame contents, with `NUM_WORDS`=2, `PERF_FRAME_CHECKSUM_EN` defined, and a `uart_tx` model that holds busy 10 cycles per byte:
   - Stimulus: words 0x00000001 and 0x12345678, pulse `snap_i`.
   - Required bytes: A5 02 01 00 00 00 78 56 34 12 17.
   - Required: one `frame_done_o` pulse.
2. Same stimulus with the macro undefined:
   - Required: 10 bytes ending in 12.
   - Required: `frame_done_o` pulse after byte 12.
3. Snapshot while busy:
   - Stimulus: pulse `snap_i` mid-frame, then change `data_i`.
   - Required: `snap_drop_o` pulse that cycle.
   - Required: the frame still carries the original latched words.
   - Required: no second frame starts.
4. Reset mid-frame:
   - Stimulus: assert `rstn`=0 while state is WAIT_LO on byte 5.
   - Required: all outputs 0 immediately.
   - Required: after release and a new `snap_i`, the first byte sent is A5.
5. Back-to-back frames:
   - Stimulus: hold `snap_i` high continuously.
   - Required: the next frame starts exactly 2 cycles after `frame_done_o`, with one `snap_drop_o` pulse per busy cycle.
6. Zero-latency busy and checksum wrap, with `tx_busy_i` rising the same cycle as `tx_start_o`:
   - Stimulus: `NUM_WORDS`=2, words 0xFFFFFFFF and 0xFFFFFFFF.
   - Required: no stall, 3-cycle byte spacing.
   - Required: checksum = (02 + 8·FF) mod 256 = 0xFA.
